// File: rtl/l2_types_pkg.sv
// Shared L2 types and constants: line/beat geometry, byte-address alignment
// and the cacheline adapter state encoding.
package l2_types_pkg;

    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int ADDR_WIDTH  = 32;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    localparam int OFFSET_BITS = 5;
    localparam int BEAT_IDX_W  = $clog2(BEATS);
    localparam int CNT_W       = BEAT_IDX_W + 1;

    typedef logic [BURST_WIDTH-1:0] beat_t;
    // Beat 0 occupies bits [BURST_WIDTH-1:0] of the flat line.
    typedef beat_t [BEATS-1:0]      line_t;
    typedef logic [ADDR_WIDTH-1:0]  addr_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } adapter_state_t;

    localparam addr_t OFFSET_MASK = addr_t'((1 << OFFSET_BITS) - 1);

    function automatic addr_t line_align(input addr_t a);
        return a & ~OFFSET_MASK;
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Bridges one 256-bit L2 line request to a 4-beat 64-bit memory burst and
// reassembles read beats into a full line returned with a one-cycle resp_o.
module cacheline_adapter
    import l2_types_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic [ADDR_WIDTH-1:0]  mem_address_o,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic [BURST_WIDTH-1:0] mem_wdata_o,
    input  logic [BURST_WIDTH-1:0] mem_rdata_i,
    input  logic                   mem_resp_i
);

    adapter_state_t          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    addr_t                   addr_q, addr_d;
    line_t                   line_q, line_d;
    line_t                   wbuf_q, wbuf_d;
    logic [BEAT_IDX_W-1:0]   beat_idx;
    logic                    last_beat;

    assign beat_idx  = cnt_q[BEAT_IDX_W-1:0];
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            wbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            wbuf_q  <= wbuf_d;
        end
    end

    // Counter returns to 0 on the last beat so it never leaves 0..BEATS-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        line_d  = line_q;
        wbuf_d  = wbuf_q;
        unique case (state_q)
            IDLE: begin
                if (write_i) begin
                    addr_d  = line_align(address_i);
                    wbuf_d  = line_i;
                    cnt_d   = '0;
                    state_d = WR_BURST;
                end else if (read_i) begin
                    addr_d  = line_align(address_i);
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (mem_resp_i) begin
                    line_d[beat_idx] = mem_rdata_i;
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WR_BURST: begin
                if (mem_resp_i) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Requests decode straight from state, so they are glitch-free and steady per burst.
    assign mem_read_o    = (state_q == RD_BURST);
    assign mem_write_o   = (state_q == WR_BURST);
    assign resp_o        = (state_q == DONE);
    assign mem_address_o = addr_q;
    assign mem_wdata_o   = wbuf_q[beat_idx];
    assign line_o        = line_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: drivers push expected lines/beats into
// queues and a negedge monitor pops and compares when the DUT presents them.
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  mem_address_o;
    logic         mem_read_o;
    logic         mem_write_o;
    logic [63:0]  mem_wdata_o;
    logic [63:0]  mem_rdata_i;
    logic         mem_resp_i;

    cacheline_adapter dut (
        .clk           (clk),
        .rst           (rst),
        .address_i     (address_i),
        .read_i        (read_i),
        .write_i       (write_i),
        .line_i        (line_i),
        .line_o        (line_o),
        .resp_o        (resp_o),
        .mem_address_o (mem_address_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_resp_i    (mem_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [255:0] exp_line_q[$];
    logic [63:0]  exp_wdata_q[$];
    logic [31:0]  exp_addr = '0;
    logic [255:0] cur_line = '0;
    logic         prev_resp = 1'b0;

    localparam logic [255:0] L1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WD = {64'hCAFE_F00D_1357_9BDF, 64'h0F0F_0F0F_F0F0_F0F0,
                                   64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
    localparam logic [255:0] L2 = {64'hA3A3_A3A3_0000_0003, 64'hA2A2_A2A2_0000_0002,
                                   64'hA1A1_A1A1_0000_0001, 64'hA0A0_A0A0_0000_0000};
    localparam logic [255:0] W2 = {64'h5555_0000_5555_0003, 64'h5555_0000_5555_0002,
                                   64'h5555_0000_5555_0001, 64'h5555_0000_5555_0000};
    localparam logic [255:0] L3 = {64'h7777_8888_9999_0004, 64'h7777_8888_9999_0003,
                                   64'h7777_8888_9999_0002, 64'h7777_8888_9999_0001};
    localparam logic [255:0] L4 = {64'hBEEF_0000_0000_0044, 64'hBEEF_0000_0000_0033,
                                   64'hBEEF_0000_0000_0022, 64'hBEEF_0000_0000_0011};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: address stability, exclusivity, write beats and completions.
    always @(negedge clk) begin
        if (rst) begin
            prev_resp = 1'b0;
        end else begin
            if (mem_read_o && mem_write_o) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_wr_both_high at %0t", $time);
            end
            if (mem_read_o || mem_write_o)
                check("mem_address", {224'd0, mem_address_o}, {224'd0, exp_addr});
            if (mem_write_o && mem_resp_i) begin
                if (exp_wdata_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_wbeat: got %h expected none", mem_wdata_o);
                end else begin
                    check("mem_wdata", {192'd0, mem_wdata_o}, {192'd0, exp_wdata_q.pop_front()});
                end
            end
            if (resp_o) begin
                check("resp_one_cycle", {255'd0, prev_resp}, 256'd0);
                if (exp_line_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got resp_o=1 expected none");
                end else begin
                    check("line_o_at_resp", line_o, exp_line_q.pop_front());
                end
            end
            prev_resp = resp_o;
        end
    end

    // Drives mem_resp_i per pattern bit (bit i = cycle i of the burst), ending in DONE.
    task automatic run_burst(input logic is_wr, input logic [15:0] pat, input int len,
                             input logic [255:0] rd_line);
        int k;
        k = 0;
        for (int i = 0; i < len; i++) begin
            check(is_wr ? "mem_write_held" : "mem_read_held",
                  {255'd0, (is_wr ? mem_write_o : mem_read_o)}, 256'd1);
            mem_resp_i = pat[i];
            if (pat[i]) begin
                mem_rdata_i = rd_line[k*64 +: 64];
                k++;
            end else begin
                mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            @(posedge clk); #1;
        end
        mem_resp_i  = 1'b0;
        mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
        check("resp_latency", {255'd0, resp_o}, 256'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                           input logic [15:0] pat, input int len, input bit chained);
        exp_line_q.push_back(line);
        exp_addr = addr & ~32'h1F;
        if (chained) begin
            @(posedge clk); #1;
            check("single_idle_gap", {253'd0, mem_read_o, mem_write_o, resp_o}, 256'd0);
        end else begin
            @(posedge clk); #1;
            read_i    = 1'b1;
            address_i = addr;
        end
        @(posedge clk); #1;
        run_burst(1'b0, pat, len, line);
        read_i   = 1'b0;
        cur_line = line;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input logic [15:0] pat, input int len);
        @(posedge clk); #1;
        write_i   = 1'b1;
        address_i = addr;
        line_i    = line;
        exp_addr  = addr & ~32'h1F;
        for (int i = 0; i < 4; i++) exp_wdata_q.push_back(line[i*64 +: 64]);
        exp_line_q.push_back(cur_line);
        @(posedge clk); #1;
        line_i = '1;
        run_burst(1'b1, pat, len, '0);
        write_i = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        address_i   = '0;
        read_i      = 1'b0;
        write_i     = 1'b0;
        line_i      = '0;
        mem_rdata_i = '0;
        mem_resp_i  = 1'b0;
        #12;
        check("rst_outputs", {253'd0, resp_o, mem_read_o, mem_write_o}, 256'd0);
        check("rst_line_o", line_o, 256'd0);
        check("rst_mem_address", {224'd0, mem_address_o}, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Read with back-to-back beats.
        do_read(32'h0000_1234, L1, 16'h000F, 4, 1'b0);
        @(posedge clk); #1;
        check("rd_resp_dropped", {255'd0, resp_o}, 256'd0);

        // Write with gaps; line_i is scribbled after capture.
        do_write(32'h0000_ABCD, WD, 16'h002D, 6);
        @(posedge clk); #1;
        check("wr_write_dropped", {254'd0, mem_write_o, resp_o}, 256'd0);
        check("wr_line_o_kept", line_o, L1);

        // Stalled read: 1,0,0,1,1,0,1.
        do_read(32'h0000_2040, L2, 16'h0059, 7, 1'b0);

        // Dirty miss: writeback, read_i raised in the DONE cycle.
        do_write(32'h0000_3000, W2, 16'h000F, 4);
        read_i    = 1'b1;
        address_i = 32'h0000_4008;
        do_read(32'h0000_4008, L3, 16'h000F, 4, 1'b1);

        // Reset after two read beats.
        @(posedge clk); #1;
        @(posedge clk); #1;
        read_i    = 1'b1;
        address_i = 32'h0000_5000;
        exp_addr  = 32'h0000_5000;
        @(posedge clk); #1;
        mem_resp_i  = 1'b1;
        mem_rdata_i = 64'h1234_5678_9ABC_DEF0;
        @(posedge clk); #1;
        mem_rdata_i = 64'h0FED_CBA9_8765_4321;
        @(posedge clk); #1;
        mem_resp_i = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("midrst_outputs", {253'd0, mem_read_o, mem_write_o, resp_o}, 256'd0);
        check("midrst_line_o", line_o, 256'd0);
        read_i   = 1'b0;
        cur_line = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        do_read(32'h0000_6010, L4, 16'h001B, 5, 1'b0);
        @(posedge clk); #1;

        // Spurious beat acknowledges while idle.
        mem_resp_i  = 1'b1;
        mem_rdata_i = 64'hFFFF_0000_FFFF_0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_spurious_outputs", {253'd0, resp_o, mem_read_o, mem_write_o}, 256'd0);
            check("idle_spurious_line_o", line_o, cur_line);
        end
        mem_resp_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        check("queues_drained", 256'(exp_line_q.size() + exp_wdata_q.size()), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
